// File: rtl/mem_read_arbiter_pkg.sv
// mem_read_arbiter_pkg: shared widths, free-path FSM states and read tag type for the egress read arbiter.
package mem_read_arbiter_pkg;
  localparam int ADDR_W = 10;
  localparam int BLOCK_BITS = 32;
  function automatic int port_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int PORT_W = port_w(4);
  typedef enum logic {FL_IDLE, FL_REQ} fl_state_t;
  typedef struct packed {
    logic valid;
    logic [PORT_W-1:0] port;
  } rd_tag_t;
endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    int c;
    c = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any = 1'b1;
        gnt[c] = 1'b1;
        idx = W'(c);
      end
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin arbitration of TX read controllers onto the packet-memory read port
// with tagged data return, plus round-robin arbitration of block frees onto the free-list interface.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int MEM_RD_LAT = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                rd_req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    rd_addr_i,
  output logic [NUM_PORTS-1:0]                rd_gnt_o,
  output logic [NUM_PORTS-1:0]                rd_rvalid_o,
  output logic [BLOCK_BITS-1:0]               rd_rdata_o,
  output logic                                mem_re_o,
  output logic [ADDR_W-1:0]                   mem_raddr_o,
  input  logic [BLOCK_BITS-1:0]               mem_rdata_i,
  input  logic [NUM_PORTS-1:0]                fl_free_req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    fl_free_idx_i,
  output logic [NUM_PORTS-1:0]                fl_free_ack_o,
  output logic                                fl_free_req_o,
  output logic [ADDR_W-1:0]                   fl_free_idx_o,
  input  logic                                fl_free_gnt_i
);
  localparam int PW = port_w(NUM_PORTS);
  typedef struct packed {
    logic valid;
    logic [PW-1:0] port;
  } tag_t;
  logic [PW-1:0] rd_ptr, rd_win, fl_ptr, fl_win;
  logic rd_any, fl_any, fl_take;
  fl_state_t state;
  tag_t tag [MEM_RD_LAT+1];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] w);
    return (int'(w) == NUM_PORTS - 1) ? '0 : w + 1'b1;
  endfunction
  // Requests are masked during reset so grants and acks drop immediately with rst_n.
  assign fl_take = (state == FL_IDLE) || fl_free_gnt_i;
  rr_pick #(.N(NUM_PORTS), .W(PW)) u_rd_pick (
    .req(rd_req_i & {NUM_PORTS{rst_n}}),
    .ptr(rd_ptr),
    .gnt(rd_gnt_o),
    .idx(rd_win),
    .any(rd_any)
  );
  rr_pick #(.N(NUM_PORTS), .W(PW)) u_fl_pick (
    .req(fl_free_req_i & {NUM_PORTS{rst_n & fl_take}}),
    .ptr(fl_ptr),
    .gnt(fl_free_ack_o),
    .idx(fl_win),
    .any(fl_any)
  );
  assign rd_rdata_o = mem_rdata_i;
  assign fl_free_req_o = (state == FL_REQ);
  always_comb begin
    rd_rvalid_o = '0;
    if (tag[MEM_RD_LAT].valid) rd_rvalid_o[tag[MEM_RD_LAT].port] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_re_o <= 1'b0;
      mem_raddr_o <= '0;
      rd_ptr <= '0;
      for (int k = 0; k <= MEM_RD_LAT; k++) tag[k] <= '0;
    end else begin
      mem_re_o <= rd_any;
      if (rd_any) begin
        mem_raddr_o <= rd_addr_i[rd_win];
        rd_ptr <= nxt(rd_win);
      end
      tag[0] <= '{valid: rd_any, port: rd_win};
      for (int k = 1; k <= MEM_RD_LAT; k++) tag[k] <= tag[k-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FL_IDLE;
      fl_ptr <= '0;
      fl_free_idx_o <= '0;
    end else if (fl_any) begin
      state <= FL_REQ;
      fl_ptr <= nxt(fl_win);
      fl_free_idx_o <= fl_free_idx_i[fl_win];
    end else if (state == FL_REQ && fl_free_gnt_i) begin
      state <= FL_IDLE;
    end
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: randomized and directed stimulus against a queue-based reference model,
// with an independent monitor popping expected memory reads, data returns and frees.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;
  localparam int NP = 4;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] rd_req_i, rd_gnt_o, rd_rvalid_o, fl_free_req_i, fl_free_ack_o;
  logic [NP-1:0][ADDR_W-1:0] rd_addr_i, fl_free_idx_i;
  logic [BLOCK_BITS-1:0] rd_rdata_o, mem_rdata_i;
  logic mem_re_o, fl_free_req_o, fl_free_gnt_i;
  logic [ADDR_W-1:0] mem_raddr_o, fl_free_idx_o;

  mem_read_arbiter #(.NUM_PORTS(NP), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .fl_free_req_i(fl_free_req_i), .fl_free_idx_i(fl_free_idx_i), .fl_free_ack_o(fl_free_ack_o),
    .fl_free_req_o(fl_free_req_o), .fl_free_idx_o(fl_free_idx_o), .fl_free_gnt_i(fl_free_gnt_i)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  typedef struct {logic [ADDR_W-1:0] addr; int due;} mem_e;
  typedef struct {int port; int due; logic [BLOCK_BITS-1:0] data;} ret_e;
  mem_e mem_q[$];
  ret_e ret_q[$];
  logic [ADDR_W-1:0] free_q[$];
  logic [BLOCK_BITS-1:0] pend[int];
  int rd_ptr_m = 0;
  int fl_ptr_m = 0;
  bit fl_busy = 0;
  logic [NP-1:0] rd_done, fl_done;

  // Memory content model: data is a fixed scramble of the address.
  function automatic logic [BLOCK_BITS-1:0] pat(input logic [ADDR_W-1:0] a);
    return (BLOCK_BITS'(a) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic int pick(input logic [NP-1:0] r, input int p);
    for (int k = 0; k < NP; k++) if (r[(p + k) % NP]) return (p + k) % NP;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides grants/acks and pushes expected responses.
  always @(negedge clk) begin
    int w;
    logic [NP-1:0] eg, ea;
    #1;
    if (!rst_n) begin
      chk("reset_outputs", 64'({rd_gnt_o, rd_rvalid_o, mem_re_o, mem_raddr_o, fl_free_ack_o,
                                fl_free_req_o, fl_free_idx_o}), 64'(0));
      rd_ptr_m = 0;
      fl_ptr_m = 0;
      fl_busy = 0;
      mem_q.delete();
      ret_q.delete();
      free_q.delete();
      pend.delete();
    end else begin
      eg = '0;
      w = pick(rd_req_i, rd_ptr_m);
      if (w >= 0) begin
        eg[w] = 1'b1;
        rd_ptr_m = (w + 1) % NP;
        rd_done[w] = 1'b1;
        mem_q.push_back('{addr: rd_addr_i[w], due: cyc + 1});
        ret_q.push_back('{port: w, due: cyc + 1 + LAT, data: pat(rd_addr_i[w])});
      end
      chk("rd_gnt", 64'(rd_gnt_o), 64'(eg));
      ea = '0;
      if (fl_busy && fl_free_gnt_i) fl_busy = 0;
      if (!fl_busy) begin
        w = pick(fl_free_req_i, fl_ptr_m);
        if (w >= 0) begin
          ea[w] = 1'b1;
          fl_ptr_m = (w + 1) % NP;
          fl_busy = 1;
          fl_done[w] = 1'b1;
          free_q.push_back(fl_free_idx_i[w]);
        end
      end
      chk("fl_ack", 64'(fl_free_ack_o), 64'(ea));
    end
  end

  // Monitor: pops expected responses whenever the DUT presents them.
  always @(negedge clk) if (rst_n) begin
    bit e;
    e = mem_q.size() > 0 && mem_q[0].due == cyc;
    chk("mem_re", 64'(mem_re_o), 64'(e));
    if (mem_re_o) pend[cyc + LAT] = pat(mem_raddr_o);
    if (e) begin
      chk("mem_raddr", 64'(mem_raddr_o), 64'(mem_q[0].addr));
      void'(mem_q.pop_front());
    end
    e = ret_q.size() > 0 && ret_q[0].due == cyc;
    chk("rd_rvalid", 64'(rd_rvalid_o), e ? (64'(1) << ret_q[0].port) : 64'(0));
    if (e) begin
      chk("rd_rdata", 64'(rd_rdata_o), 64'(ret_q[0].data));
      void'(ret_q.pop_front());
    end
    e = free_q.size() > 0;
    chk("fl_free_req", 64'(fl_free_req_o), 64'(e));
    if (e) begin
      chk("fl_free_idx", 64'(fl_free_idx_o), 64'(free_q[0]));
      if (fl_free_gnt_i) void'(free_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_req_i &= ~rd_done;
    fl_free_req_i &= ~fl_done;
    rd_done = '0;
    fl_done = '0;
    if (pend.exists(cyc)) begin
      mem_rdata_i = pend[cyc];
      pend.delete(cyc);
    end else mem_rdata_i = $urandom;
  endtask

  task automatic drained();
    chk("queues_drained", 64'(mem_q.size() + ret_q.size() + free_q.size()), 64'(0));
  endtask

  initial begin
    rd_req_i = '0;
    rd_addr_i = '0;
    fl_free_req_i = '0;
    fl_free_idx_i = '0;
    fl_free_gnt_i = 1'b0;
    mem_rdata_i = '0;
    rd_done = '0;
    fl_done = '0;
    repeat (3) step();
    rst_n = 1'b1;
    while (cyc < 10) step();
    rd_req_i[2] = 1'b1;
    rd_addr_i[2] = 10'h15;
    repeat (6) step();
    repeat (8) begin
      rd_req_i = '1;
      for (int p = 0; p < NP; p++) rd_addr_i[p] = ADDR_W'($urandom);
      step();
    end
    repeat (6) step();
    rd_req_i[1] = 1'b1;
    step();
    rd_req_i[1] = 1'b1;
    rd_req_i[3] = 1'b1;
    repeat (4) step();
    fl_free_req_i[0] = 1'b1;
    fl_free_idx_i[0] = 10'd7;
    fl_free_req_i[2] = 1'b1;
    fl_free_idx_i[2] = 10'd9;
    repeat (3) step();
    fl_free_gnt_i = 1'b1;
    repeat (2) step();
    fl_free_gnt_i = 1'b0;
    repeat (2) step();
    drained();
    for (int i = 0; i < 500; i++) begin
      step();
      for (int p = 0; p < NP; p++) begin
        if (!rd_req_i[p] && $urandom_range(0, 2) == 0) begin
          rd_req_i[p] = 1'b1;
          rd_addr_i[p] = ADDR_W'($urandom);
        end
        if (!fl_free_req_i[p] && $urandom_range(0, 3) == 0) begin
          fl_free_req_i[p] = 1'b1;
          fl_free_idx_i[p] = ADDR_W'($urandom);
        end
      end
      fl_free_gnt_i = $urandom_range(0, 2) != 0;
    end
    fl_free_gnt_i = 1'b1;
    repeat (15) step();
    drained();
    rd_req_i[1] = 1'b1;
    rd_addr_i[1] = 10'h2a;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd_req_i[1] = 1'b1;
    rd_req_i[3] = 1'b1;
    repeat (10) step();
    drained();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shared-resource arbiter on the egress side of the switch; read-direction counterpart of the ingress write arbiter.
- Arbitrates per-port TX memory read controllers onto the single packet-memory read port and tags each issued read with its port ID.
- Routes read data back to the owning port after the fixed memory latency.
- Arbitrates per-port block-free requests onto the single free-list free interface, so blocks return to the free list once transmitted.

Parameters:
- NUM_PORTS, 4, number of switch ports / TX read controllers; any value >= 2, power of two not required.
- MEM_RD_LAT, 2, cycles from mem_re_o asserted to mem_rdata_i valid; >= 1.
- ADDR_W and BLOCK_BITS come from the shared package, not from module parameters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rd_req_i  in  [NUM_PORTS]x1  per-port read request; held until granted.
- rd_addr_i  in  [NUM_PORTS]xADDR_W  per-port block address.
- rd_gnt_o  out  [NUM_PORTS]x1  one-hot read grant, same cycle as request.
- rd_rvalid_o  out  [NUM_PORTS]x1  read data valid for that port.
- rd_rdata_o  out  BLOCK_BITS  read data, shared by all ports.
- mem_re_o  out  1  memory read enable.
- mem_raddr_o  out  ADDR_W  memory read address.
- mem_rdata_i  in  BLOCK_BITS  memory read data.
- fl_free_req_i  in  [NUM_PORTS]x1  per-port free request; held until acked.
- fl_free_idx_i  in  [NUM_PORTS]xADDR_W  block index to free.
- fl_free_ack_o  out  [NUM_PORTS]x1  one-hot: request captured, port may drop it.
- fl_free_req_o  out  1  free request to free list.
- fl_free_idx_o  out  ADDR_W  block index to free list.
- fl_free_gnt_i  in  1  free list accepted fl_free_idx_o this cycle.

Behaviour:
- Reset values: all outputs 0. Both round-robin pointers 0. Tag pipeline all invalid. Free FSM in IDLE.
- Read round-robin:
  - Winner is the first requesting port at index >= rd_ptr, wrapping modulo NUM_PORTS.
  - rd_gnt_o[winner]=1 combinationally in the same cycle T.
  - On a grant, rd_ptr <= (winner+1) mod NUM_PORTS, with explicit wrap for non-power-of-two values. With no request, rd_ptr holds.
  - At most one grant per cycle; back-to-back grants are allowed every cycle.
- Read issue:
  - mem_re_o and mem_raddr_o are registered. A grant at cycle T drives mem_re_o=1 and mem_raddr_o=rd_addr_i[winner] at T+1.
  - With no grant, mem_re_o=0 and mem_raddr_o holds its last value.
- Tag pipeline:
  - Shift register of {valid, port ID}, depth MEM_RD_LAT+1, entered at grant.
  - Port ID width is max(1,$clog2(NUM_PORTS)).
  - At T+1+MEM_RD_LAT, rd_rvalid_o[tag port]=1 for exactly one cycle.
  - rd_rdata_o = mem_rdata_i combinationally.
  - There is no backpressure; ports must accept rvalid. Return order equals grant order.
- Free FSM, states IDLE and REQ:
  - IDLE: if any fl_free_req_i, pick a winner by round-robin from fl_ptr and assert fl_free_ack_o[winner] (combinational). Capture fl_free_idx_i[winner] into fl_free_idx_o, advance fl_ptr, go to REQ. fl_free_req_o is registered =1 in REQ.
  - REQ with fl_free_gnt_i=0: hold fl_free_req_o and fl_free_idx_o stable. No ack.
  - REQ with fl_free_gnt_i=1: if another request is pending, ack and capture it in the same cycle and stay in REQ (back-to-back frees). Otherwise go to IDLE with fl_free_req_o=0.
  - fl_free_gnt_i in IDLE is ignored.
- Read and free paths are independent; simultaneous activity from the same port is legal.
- Reset mid-operation: in-flight reads are discarded (no rvalid), and a pending free is dropped. The owning port must re-request after reset.

Decomposition:
- Shared package (already holds ADDR_W and BLOCK_BITS) gains:
  - PORT_W
  - free FSM state enum
  - rd_tag_t struct {valid, port}
- One sub-module, rr_pick: parameterized combinational round-robin selector taking a request vector and pointer, returning one-hot grant, winner index and any-flag. It is instantiated twice (read path and free path).

Test Plan:
- NUM_PORTS=4, MEM_RD_LAT=2. Port 2 requests addr 0x15 at cycle 10 -> rd_gnt_o[2]@10; mem_re_o=1, mem_raddr_o=0x15@11; rd_rvalid_o[2]=1@13 with rd_rdata_o=mem_rdata_i; nothing else asserted.
- All 4 ports request continuously from ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; rvalids 3 cycles later in the same order; no gaps.
- ptr=2, ports 1 and 3 requesting -> grant 3 first, then 1; ptr ends at 2. With NUM_PORTS=3: grant to port 2 wraps ptr to 0.
- Ports 0 and 2 free idx 7 and 9 together, fl_free_gnt_i low 3 cycles -> ack[0] first; fl_free_req_o=1 with idx 7 held stable; on gnt, ack[2] the same cycle; idx 9 presented the next cycle; after its gnt, FSM returns to IDLE and fl_free_req_o=0.
- rst_n pulsed low 1 cycle after a grant to port 1 -> all outputs 0 immediately; no rd_rvalid_o[1] ever; after release, first requester from port 0 upward wins.
